// File: rtl/pipe_sub_pkg.sv
// Shared definitions for the pipelined subtract/compare block:
// representation selectors and the per-stage flag layout.
package pipe_sub_pkg;

  localparam string REP_UNSIGNED = "UNSIGNED";
  localparam string REP_SIGNED   = "SIGNED";

  // Flag half of the stage payload; the WIDTH-bit result sits above it.
  typedef struct packed {
    logic bout;
    logic overflow;
    logic eq;
    logic lt;
  } sub_flags_t;

  localparam int FLAGS_W = $bits(sub_flags_t);

endpackage

// File: rtl/pipe_sub_if.sv
// Valid/ready bus for pipe_sub: operand beat in, result/flags beat out.
interface pipe_sub_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             bout;
  logic             overflow;
  logic             eq;
  logic             lt;

  modport master (
    output in_valid, dataa, datab, bin, out_ready,
    input  in_ready, out_valid, result, bout, overflow, eq, lt
  );

  modport slave (
    input  in_valid, dataa, datab, bin, out_ready,
    output in_ready, out_valid, result, bout, overflow, eq, lt
  );
endinterface

// File: rtl/pipe_sub_stage.sv
// One valid/ready payload register; refills in the same cycle it drains
// so bubbles collapse and a full chain still moves one beat per cycle.
module pipe_sub_stage #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);
  logic          vld_q, vld_d;
  logic [DW-1:0] data_q, data_d;
  logic          load;

  always_comb begin
    load   = in_valid && (!vld_q || out_ready);
    vld_d  = load || (vld_q && !out_ready);
    data_d = load ? in_data : data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
endmodule

// File: rtl/pipe_sub.sv
// Pipelined subtractor with borrow-in: combinational subtract/compare front
// end feeding STAGES elastic payload registers; outputs come straight from flops.
module pipe_sub
  import pipe_sub_pkg::*;
#(
  parameter int    WIDTH          = 8,
  parameter int    STAGES         = 2,
  parameter string REPRESENTATION = "UNSIGNED"
) (
  input logic        clock,
  input logic        reset,
  pipe_sub_if.slave  bus
);
  localparam bit IS_SIGNED = (REPRESENTATION == REP_SIGNED);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    sub_flags_t       flags;
  } payload_t;

  localparam int PL_W = $bits(payload_t);

  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0]           rdy_pipe;
  logic [STAGES:0][PL_W-1:0] data_pipe;

  payload_t         fe_pl;
  payload_t         out_pl;
  logic [WIDTH:0]   udiff;

  // a - b - bin == a + ~b + !bin, so the usual add-overflow rule applies
  // with ~b as the second operand.
  always_comb begin
    udiff                = {1'b0, bus.dataa} - {1'b0, bus.datab} - {{WIDTH{1'b0}}, bus.bin};
    fe_pl                = '0;
    fe_pl.result         = udiff[WIDTH-1:0];
    fe_pl.flags.bout     = udiff[WIDTH];
    fe_pl.flags.eq       = (bus.dataa == bus.datab);
    if (IS_SIGNED) begin
      fe_pl.flags.overflow = (bus.dataa[WIDTH-1] != bus.datab[WIDTH-1]) &&
                             (udiff[WIDTH-1] != bus.dataa[WIDTH-1]);
      fe_pl.flags.lt       = ($signed(bus.dataa) < $signed(bus.datab));
    end else begin
      fe_pl.flags.overflow = udiff[WIDTH];
      fe_pl.flags.lt       = (bus.dataa < bus.datab);
    end
  end

  assign vld_pipe[0]  = bus.in_valid;
  assign data_pipe[0] = fe_pl;

  // Ready ripples back from out_ready through every stage that is full.
  always_comb begin
    rdy_pipe         = '0;
    rdy_pipe[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      rdy_pipe[k] = !vld_pipe[k+1] || rdy_pipe[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_sub_stage #(.DW(PL_W)) u_stage (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (vld_pipe[k]),
      .in_data   (data_pipe[k]),
      .out_ready (rdy_pipe[k+1]),
      .out_valid (vld_pipe[k+1]),
      .out_data  (data_pipe[k+1])
    );
  end

  assign out_pl       = data_pipe[STAGES];
  assign bus.in_ready = rdy_pipe[0];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.result   = out_pl.result;
  assign bus.bout     = out_pl.flags.bout;
  assign bus.overflow = out_pl.flags.overflow;
  assign bus.eq       = out_pl.flags.eq;
  assign bus.lt       = out_pl.flags.lt;
endmodule
